// File: rtl/fe_branch_predictor_pkg.sv
// Shared constants, the AGEX->FE resolution bundle layout and the 2-bit
// saturating counter step used by the gshare PHT.
package fe_branch_predictor_pkg;
  localparam int BHR_BITS     = 8;
  localparam int BTB_IDX_BITS = 4;
  localparam int DBITS        = 32;
  localparam logic [1:0] PHT_INIT = 2'b01;

  localparam int FROM_AGEX_TO_FE_WIDTH = DBITS + 1 + 1 + BHR_BITS + BHR_BITS + DBITS;

  typedef struct packed {
    logic [DBITS-1:0]    jump_target;
    logic                br_cond;
    logic                prediction_correct;
    logic [BHR_BITS-1:0] pht_index;
    logic [BHR_BITS-1:0] new_bhr;
    logic [DBITS-1:0]    pc;
  } from_agex_to_fe_t;

  function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/fe_branch_predictor_if.sv
// FE <-> predictor bus: lookup, AGEX resolution feedback and statistics.
interface fe_branch_predictor_if #(
  parameter int BHR_BITS = 8,
  parameter int DBITS    = 32
);
  logic [DBITS-1:0]    pc_fe;
  logic                lookup_valid;
  logic                pred_taken;
  logic [DBITS-1:0]    pred_next_pc;
  logic [BHR_BITS-1:0] pred_bhr;
  logic                upd_valid;
  logic [DBITS-1:0]    upd_pc;
  logic [DBITS-1:0]    upd_target;
  logic                upd_taken;
  logic                upd_mispredict;
  logic [BHR_BITS-1:0] upd_pht_idx;
  logic [BHR_BITS-1:0] upd_new_bhr;
  logic [31:0]         stat_lookups;
  logic [31:0]         stat_updates;
  logic [31:0]         stat_mispredicts;

  modport master (
    output pc_fe, lookup_valid, upd_valid, upd_pc, upd_target, upd_taken,
           upd_mispredict, upd_pht_idx, upd_new_bhr,
    input  pred_taken, pred_next_pc, pred_bhr, stat_lookups, stat_updates, stat_mispredicts
  );
  modport slave (
    input  pc_fe, lookup_valid, upd_valid, upd_pc, upd_target, upd_taken,
           upd_mispredict, upd_pht_idx, upd_new_bhr,
    output pred_taken, pred_next_pc, pred_bhr, stat_lookups, stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/fe_branch_predictor_bp_pht.sv
// Pattern history table: 2^IDX_BITS saturating 2-bit counters, one
// combinational read port and one training write port.
module fe_branch_predictor_bp_pht
  import fe_branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = fe_branch_predictor_pkg::BHR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);
  localparam int ENT = 1 << IDX_BITS;

  logic [1:0] cnt_q [ENT];
  logic [1:0] cnt_d [ENT];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) cnt_d[wr_idx] = sat_cnt(cnt_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENT; i++) cnt_q[i] <= PHT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read sees the registered value only, so a same-cycle update is not bypassed.
  assign rd_cnt = cnt_q[rd_idx];
endmodule

// File: rtl/fe_branch_predictor.sv
// Gshare direction predictor plus direct-mapped BTB; lookup is same-cycle,
// training from AGEX lands one cycle later. History is non-speculative.
module fe_branch_predictor
  import fe_branch_predictor_pkg::*;
#(
  parameter int BHR_BITS     = fe_branch_predictor_pkg::BHR_BITS,
  parameter int BTB_IDX_BITS = fe_branch_predictor_pkg::BTB_IDX_BITS,
  parameter int DBITS        = fe_branch_predictor_pkg::DBITS
) (
  input  logic                  clk,
  input  logic                  reset,
  fe_branch_predictor_if.slave  bp
);
  localparam int BTB_ENT = 1 << BTB_IDX_BITS;
  localparam int TAG_LO  = BTB_IDX_BITS + 2;
  localparam int TAG_W   = DBITS - TAG_LO;

  logic [BHR_BITS-1:0] bhr_q, bhr_d;
  logic [BTB_ENT-1:0]  btb_vld_q, btb_vld_d;
  logic [TAG_W-1:0]    btb_tag_q [BTB_ENT];
  logic [TAG_W-1:0]    btb_tag_d [BTB_ENT];
  logic [DBITS-1:0]    btb_tgt_q [BTB_ENT];
  logic [DBITS-1:0]    btb_tgt_d [BTB_ENT];
  logic [31:0]         lookups_q, lookups_d;
  logic [31:0]         updates_q, updates_d;
  logic [31:0]         mispred_q, mispred_d;

  logic [BHR_BITS-1:0]     pht_rd_idx;
  logic [1:0]              pht_rd_cnt;
  logic [BTB_IDX_BITS-1:0] btb_rd_idx, btb_wr_idx;
  logic                    btb_hit;
  logic                    unused_ok;

  assign pht_rd_idx = bhr_q ^ bp.pc_fe[BHR_BITS-1:0];
  assign btb_rd_idx = bp.pc_fe[TAG_LO-1:2];
  assign btb_wr_idx = bp.upd_pc[TAG_LO-1:2];
  assign btb_hit    = btb_vld_q[btb_rd_idx] && (btb_tag_q[btb_rd_idx] == bp.pc_fe[DBITS-1:TAG_LO]);
  assign unused_ok  = &{1'b0, bp.upd_pc[1:0]};

  fe_branch_predictor_bp_pht #(.IDX_BITS(BHR_BITS)) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pht_rd_idx),
    .rd_cnt   (pht_rd_cnt),
    .wr_en    (bp.upd_valid),
    .wr_idx   (bp.upd_pht_idx),
    .wr_taken (bp.upd_taken)
  );

  assign bp.pred_taken       = btb_hit && pht_rd_cnt[1];
  assign bp.pred_next_pc     = bp.pred_taken ? btb_tgt_q[btb_rd_idx] : bp.pc_fe + DBITS'(4);
  assign bp.pred_bhr         = bhr_q;
  assign bp.stat_lookups     = lookups_q;
  assign bp.stat_updates     = updates_q;
  assign bp.stat_mispredicts = mispred_q;

  always_comb begin
    bhr_d     = bhr_q;
    btb_vld_d = btb_vld_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    lookups_d = lookups_q + {31'd0, bp.lookup_valid};
    updates_d = updates_q + {31'd0, bp.upd_valid};
    mispred_d = mispred_q + {31'd0, bp.upd_valid && bp.upd_mispredict};
    if (bp.upd_valid) begin
      bhr_d = bp.upd_new_bhr;
      // Taken branches claim the slot unconditionally; aliases simply evict.
      if (bp.upd_taken) begin
        btb_vld_d[btb_wr_idx] = 1'b1;
        btb_tag_d[btb_wr_idx] = bp.upd_pc[DBITS-1:TAG_LO];
        btb_tgt_d[btb_wr_idx] = bp.upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bhr_q     <= '0;
      btb_vld_q <= '0;
      for (int i = 0; i < BTB_ENT; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
      lookups_q <= '0;
      updates_q <= '0;
      mispred_q <= '0;
    end else begin
      bhr_q     <= bhr_d;
      btb_vld_q <= btb_vld_d;
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
      lookups_q <= lookups_d;
      updates_q <= updates_d;
      mispred_q <= mispred_d;
    end
  end
endmodule

// File: tb/tb_fe_branch_predictor.sv
// Directed bench for fe_branch_predictor: reset, training latency, PHT
// saturation, BTB aliasing, mispredict history and asynchronous reset.
module tb_fe_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_upd = 0;

  always #5 clk = ~clk;

  fe_branch_predictor_if bp_if ();

  fe_branch_predictor dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one update pulse; caller sits at posedge+1, returns at posedge+1.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                     input logic misp, input logic [7:0] idx, input logic [7:0] nbhr);
    bp_if.upd_valid      = 1'b1;
    bp_if.upd_pc         = pc;
    bp_if.upd_target     = tgt;
    bp_if.upd_taken      = taken;
    bp_if.upd_mispredict = misp;
    bp_if.upd_pht_idx    = idx;
    bp_if.upd_new_bhr    = nbhr;
    n_upd++;
    @(posedge clk);
    #1;
    bp_if.upd_valid      = 1'b0;
    bp_if.upd_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bp_if.pc_fe = pc;
    #1;
  endtask

  initial begin
    reset                = 1'b0;
    bp_if.pc_fe          = 32'h100;
    bp_if.lookup_valid   = 1'b0;
    bp_if.upd_valid      = 1'b0;
    bp_if.upd_pc         = '0;
    bp_if.upd_target     = '0;
    bp_if.upd_taken      = 1'b0;
    bp_if.upd_mispredict = 1'b0;
    bp_if.upd_pht_idx    = '0;
    bp_if.upd_new_bhr    = '0;
    #2;
    chk("rst_taken", {31'd0, bp_if.pred_taken}, 32'd0);
    chk("rst_next",  bp_if.pred_next_pc, 32'h104);
    chk("rst_bhr",   {24'd0, bp_if.pred_bhr}, 32'd0);
    chk("rst_lkp",   bp_if.stat_lookups, 32'd0);
    chk("rst_upd",   bp_if.stat_updates, 32'd0);
    chk("rst_mis",   bp_if.stat_mispredicts, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // exactly three lookup cycles
    bp_if.lookup_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bp_if.lookup_valid = 1'b0;
    chk("lookups3", bp_if.stat_lookups, 32'd3);

    // first training: same cycle sees nothing, next cycle BHR moves
    bp_if.upd_valid = 1'b1; bp_if.upd_pc = 32'h100; bp_if.upd_target = 32'h80;
    bp_if.upd_taken = 1'b1; bp_if.upd_pht_idx = 8'h00; bp_if.upd_new_bhr = 8'h01;
    #1;
    chk("same_cyc_taken", {31'd0, bp_if.pred_taken}, 32'd0);
    chk("same_cyc_bhr",   {24'd0, bp_if.pred_bhr}, 32'd0);
    n_upd++;
    @(posedge clk);
    #1 bp_if.upd_valid = 1'b0;
    chk("bhr_01",     {24'd0, bp_if.pred_bhr}, 32'h01);
    chk("idx01_weak", {31'd0, bp_if.pred_taken}, 32'd0);
    chk("idx01_next", bp_if.pred_next_pc, 32'h104);
    chk("upd_cnt1",   bp_if.stat_updates, 32'd1);

    // train PHT[0x01]; the lookup in the update cycle must stay not-taken
    bp_if.upd_valid = 1'b1; bp_if.upd_pht_idx = 8'h01;
    #1 chk("no_bypass", {31'd0, bp_if.pred_taken}, 32'd0);
    n_upd++;
    @(posedge clk);
    #1 bp_if.upd_valid = 1'b0;
    chk("hit_taken", {31'd0, bp_if.pred_taken}, 32'd1);
    chk("hit_next",  bp_if.pred_next_pc, 32'h80);

    // saturation at PHT[0x10], looked up through BHR=0x10 at pc 0x100
    repeat (5) upd(32'h100, 32'h80, 1'b1, 1'b0, 8'h10, 8'h10);
    chk("sat_hi_taken", {31'd0, bp_if.pred_taken}, 32'd1);
    upd(32'h100, 32'h80, 1'b0, 1'b0, 8'h10, 8'h10);
    chk("sat_hi_minus1", {31'd0, bp_if.pred_taken}, 32'd1);
    chk("sat_hi_next",   bp_if.pred_next_pc, 32'h80);
    upd(32'h100, 32'h80, 1'b0, 1'b0, 8'h10, 8'h10);
    upd(32'h100, 32'h80, 1'b0, 1'b0, 8'h10, 8'h10);
    chk("cnt0_taken", {31'd0, bp_if.pred_taken}, 32'd0);
    chk("cnt0_next",  bp_if.pred_next_pc, 32'h104);
    upd(32'h100, 32'h80, 1'b0, 1'b0, 8'h10, 8'h10);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 8'h10, 8'h10);
    chk("sat_lo_hold", {31'd0, bp_if.pred_taken}, 32'd0);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 8'h10, 8'h10);
    chk("sat_lo_recover", {31'd0, bp_if.pred_taken}, 32'd1);

    // BTB alias: 0x140 evicts 0x100 at index 0; BHR=0 so 0x140 uses PHT[0x40]
    upd(32'h140, 32'h200, 1'b1, 1'b0, 8'h40, 8'h00);
    look(32'h100);
    chk("alias_miss_taken", {31'd0, bp_if.pred_taken}, 32'd0);
    chk("alias_miss_next",  bp_if.pred_next_pc, 32'h104);
    look(32'h140);
    chk("alias_hit_taken", {31'd0, bp_if.pred_taken}, 32'd1);
    chk("alias_hit_next",  bp_if.pred_next_pc, 32'h200);

    // mispredicted not-taken at 0x100 must not touch the BTB
    upd(32'h100, 32'h300, 1'b0, 1'b1, 8'h00, 8'hA5);
    chk("mis_bhr", {24'd0, bp_if.pred_bhr}, 32'hA5);
    chk("mis_cnt", bp_if.stat_mispredicts, 32'd1);
    // arm PHT[0xA5^0x40] via an unrelated BTB slot
    upd(32'h104, 32'h400, 1'b1, 1'b0, 8'hE5, 8'hA5);
    look(32'h140);
    chk("nt_keeps_btb", bp_if.pred_next_pc, 32'h200);
    look(32'h104);
    chk("slot1_next", bp_if.pred_next_pc, 32'h108);
    chk("upd_total", bp_if.stat_updates, n_upd);
    chk("mis_total", bp_if.stat_mispredicts, 32'd1);
    chk("lkp_hold",  bp_if.stat_lookups, 32'd3);

    // asynchronous reset between edges
    look(32'h140);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_taken", {31'd0, bp_if.pred_taken}, 32'd0);
    chk("arst_next",  bp_if.pred_next_pc, 32'h144);
    chk("arst_bhr",   {24'd0, bp_if.pred_bhr}, 32'd0);
    chk("arst_upd",   bp_if.stat_updates, 32'd0);
    chk("arst_mis",   bp_if.stat_mispredicts, 32'd0);
    chk("arst_lkp",   bp_if.stat_lookups, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    look(32'h100);
    chk("post_rst_next", bp_if.pred_next_pc, 32'h104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
